// File: rtl/fft_bf_scheduler.sv
// fft_bf_scheduler: sequences one shared radix-2 DIT butterfly over an in-place N-point FFT.
// Optional macro FFT_SCHED_HOLD_EN adds a hold input that stalls issue in ISSUE.
module fft_bf_scheduler #(
  parameter int LOG2N = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef FFT_SCHED_HOLD_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             bf_valid,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);
  localparam int DL = RD_LAT + BF_LAT;
  localparam int CW = $clog2(DL + 2);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(LOG2N - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [LOG2N-2:0] k, go_k;
  logic [LOG2N-1:0] go_s, go_a, half, j;
  logic [CW-1:0] dcnt;
  logic go, hold_i;
  logic [2*LOG2N:0] pipe [DL];

`ifdef FFT_SCHED_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  // go: a butterfly is issued at this edge; k holds the next butterfly to issue
  always_comb begin
    go = (state == IDLE && start) || (state == ISSUE && !hold_i) ||
         (state == DRAIN && dcnt == CW'(DL) && stage != LAST);
    go_k = state == ISSUE ? k : '0;
    go_s = state == DRAIN ? stage + 1'b1 : state == ISSUE ? stage : '0;
    half = LOG2N'(1) << go_s;
    j = LOG2N'(go_k) & (half - 1'b1);
    go_a = ((LOG2N'(go_k) >> go_s) << (go_s + 1'b1)) | j;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      k <= '0;
      stage <= '0;
      dcnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_en <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr <= '0;
    end else begin
      rd_en <= go;
      done <= 1'b0;
      if (go) begin
        state <= &go_k ? DRAIN : ISSUE;
        k <= go_k + 1'b1;
        stage <= go_s;
        dcnt <= '0;
        busy <= 1'b1;
        rd_addr_a <= go_a;
        rd_addr_b <= go_a + half;
        tw_addr <= j[LOG2N-2:0] << (LAST - go_s);
      end else if (state == DRAIN) begin
        if (dcnt == CW'(DL)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end else dcnt <= dcnt + 1'b1;
      end else if (state == DONE) state <= IDLE;
    end

  // write-back shadow of the read stream; shifts in every state so DRAIN flushes it
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < DL; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < DL; i++) pipe[i] <= pipe[i-1];
    end

  assign bf_valid = pipe[RD_LAT-1][2*LOG2N];
  assign {wr_en, wr_addr_a, wr_addr_b} = pipe[DL-1];
endmodule
